rv32i_register_file: RTL and testbench
======================================

# rv32i_register_file

Multicycle, single-port RV32I integer register file (x0–x31) that answers the decode stage's register request interface. It accepts one request at a time:
- a read, write or clear request is presented on level-held enables;
- it is answered with a one-cycle `valid` pulse.

It sits beside the instruction-decode stage and is the responder for its `o_register_*` outputs and `i_register_*` inputs.

## Interface
Parameters:
- `WORD_SIZE`, 32, register width in bits.
- `NUM_REGS`, 32, number of architectural registers; the address width is fixed at 5.

Ports (clock and reset first):
- `i_clk`  input  1  core clock; all state changes on its rising edge.
- `i_rst`  input  1  reset, synchronous, active-high.
- `i_register_rst`  input  1  request a clear sweep of x1–x31.
- `i_register_read_en`  input  1  read request, held until `o_register_read_valid` is seen.
- `i_register_write_en`  input  1  write request, held until `o_register_write_valid` is seen.
- `i_register_addr`  input  5  target register index.
- `i_register_write_data`  input  WORD_SIZE  data for a write.
- `o_register_read_data`  output  WORD_SIZE  read result; valid only while `o_register_read_valid` is high.
- `o_register_read_valid`  output  1  one-cycle read completion pulse.
- `o_register_write_valid`  output  1  one-cycle write completion pulse.
- `o_register_busy`  output  1  high in any state other than IDLE.

## Operation
FSM states: IDLE, READ_RESP, WRITE_RESP, CLEAR.

IDLE samples requests with fixed priority: `i_register_rst` > `i_register_write_en` > `i_register_read_en`.
- **Clear:** `i_register_rst` → CLEAR with the sweep counter set to 1.
- **Write:** `i_register_write_en` → the array entry at `i_register_addr` is written with `i_register_write_data` on that edge → WRITE_RESP.
  - Address 0: the write is discarded, but the response is still given.
- **Read:** `i_register_read_en` → `o_register_read_data` is registered from the array → READ_RESP.
  - Address 0: the registered data is 0.
- **Simultaneous read and write enables:** only the write is accepted. The read stays pending and is accepted in the next IDLE cycle, so it returns the newly written value when the addresses match.

Response states:
- READ_RESP: `o_register_read_valid` = 1, then → IDLE.
- WRITE_RESP: `o_register_write_valid` = 1, then → IDLE.
- No request is sampled in a response state.
- The requester must deassert its enable at the edge that ends the valid cycle. An enable still high in the following IDLE cycle is treated as a new request.

CLEAR:
- Writes 0 to the entry at the counter each cycle and increments it, covering 1 to 31.
- After writing entry 31 → IDLE.
- Read and write enables are ignored throughout.

Other rules:
- x0 is never stored and always reads 0.
- `o_register_read_data` holds its last value outside READ_RESP.

## Timing
- Reset (`i_rst` high at an edge): state → IDLE, sweep counter → 0, and `o_register_read_data`, `o_register_read_valid`, `o_register_write_valid`, `o_register_busy` → 0.
  - Array contents are not reset.
  - Reset mid-sweep or mid-response aborts it; a pending valid pulse is never produced.
- Read: request sampled at edge N; data and valid are both high in cycle N+1.
- Write: array updated at edge N; `o_register_write_valid` is high in cycle N+1. A read accepted at edge N+2 or later sees the new value.
- Throughput: one request per 2 cycles.
- Clear duration: 31 cycles in CLEAR; `o_register_busy` is high for exactly 31 cycles, then IDLE.
- `i_register_rst` asserted outside IDLE is ignored; it is not latched.

## Configuration
- **`REGFILE_CLEAR_SWEEP_EN` defined:** CLEAR state, sweep counter and `i_register_rst` handling are built as described above.
- **`REGFILE_CLEAR_SWEEP_EN` undefined:**
  - CLEAR and the counter are not built, and `i_register_rst` is ignored.
  - Priority becomes write > read.
  - `o_register_busy` is high only in the response states.
  - Register contents are undefined until written; x0 still reads 0.

## Test plan
- Write x5 = 0xDEADBEEF, drop enable, then read x5 → `o_register_write_valid` pulses 1 cycle after the write request; `o_register_read_valid` pulses with data 0xDEADBEEF 1 cycle after the read request.
- Write x0 = 0x12345678, then read x0 → write valid pulses; read data = 0x00000000.
- Read and write enables both high, address 7, write data 0xA5A5A5A5 → write valid at N+1; read accepted at N+2; read valid at N+3 with 0xA5A5A5A5.
- Fill x1–x31 with index values, pulse `i_register_rst` (macro defined) → busy high for 31 cycles; enables during the sweep are ignored; afterwards every register reads 0.
- Assert `i_rst` during cycle 10 of a sweep → next cycle all outputs are 0 and the state is IDLE. A read of x20 returns its pre-sweep value; a read of x5 returns 0.
- Hold `i_register_read_en` high for 4 cycles on x3 → valid pulses at cycles 1 and 3 (two reads); no valid in cycles 0 or 2.

Source files
------------

// File: rtl/rv32i_register_file_if.sv
// Request/response bundle between the decode stage (master) and the RV32I register file (slave).
// Handshake: the master holds exactly one of the enables until the matching one-cycle valid pulse is seen, and drops it at the edge that ends that pulse.
interface rv32i_register_file_if #(
  parameter int WORD_SIZE = 32
);
  logic                 i_register_rst;
  logic                 i_register_read_en;
  logic                 i_register_write_en;
  logic [4:0]           i_register_addr;
  logic [WORD_SIZE-1:0] i_register_write_data;
  logic [WORD_SIZE-1:0] o_register_read_data;
  logic                 o_register_read_valid;
  logic                 o_register_write_valid;
  logic                 o_register_busy;

  modport master (
    output i_register_rst,
    output i_register_read_en,
    output i_register_write_en,
    output i_register_addr,
    output i_register_write_data,
    input  o_register_read_data,
    input  o_register_read_valid,
    input  o_register_write_valid,
    input  o_register_busy
  );

  modport slave (
    input  i_register_rst,
    input  i_register_read_en,
    input  i_register_write_en,
    input  i_register_addr,
    input  i_register_write_data,
    output o_register_read_data,
    output o_register_read_valid,
    output o_register_write_valid,
    output o_register_busy
  );
endinterface

// File: rtl/rv32i_register_file.sv
// Multicycle single-port RV32I register file (x0 hardwired to zero), one request per two cycles.
// Optional clear sweep of x1..x31 is built when REGFILE_CLEAR_SWEEP_EN is defined.
module rv32i_register_file #(
  parameter int WORD_SIZE = 32,
  parameter int NUM_REGS  = 32
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  rv32i_register_file_if.slave         bus,
  output logic [1:0]                   dbg_state
);

  localparam logic [5:0] REG_LIMIT = 6'(NUM_REGS);
  localparam logic [4:0] LAST_REG  = 5'(NUM_REGS - 1);

`ifdef REGFILE_CLEAR_SWEEP_EN
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_RESP  = 2'd1,
    WRITE_RESP = 2'd2,
    CLEAR      = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_RESP  = 2'd1,
    WRITE_RESP = 2'd2
  } state_t;
`endif

  state_t               state;
  logic [WORD_SIZE-1:0] regs [1:NUM_REGS-1];

  logic                 clear_req;
  logic                 accept_write;
  logic                 accept_read;
  logic                 addr_ok;
  logic [WORD_SIZE-1:0] read_val;
  logic                 arr_we;
  logic [4:0]           arr_waddr;
  logic [WORD_SIZE-1:0] arr_wdata;

`ifdef REGFILE_CLEAR_SWEEP_EN
  logic [4:0] sweep_cnt;
  assign clear_req = (state == IDLE) && bus.i_register_rst;
`else
  logic unused_register_rst;
  assign unused_register_rst = bus.i_register_rst;
  assign clear_req           = 1'b0;
`endif

  // A write wins over a simultaneous read; the held read is picked up in the next IDLE cycle.
  assign accept_write = (state == IDLE) && !clear_req && bus.i_register_write_en;
  assign accept_read  = (state == IDLE) && !clear_req && !bus.i_register_write_en
                        && bus.i_register_read_en;
  assign addr_ok      = {1'b0, bus.i_register_addr} < REG_LIMIT;

  always_comb begin
    read_val = '0;
    if (addr_ok && (bus.i_register_addr != 5'd0)) begin
      read_val = regs[bus.i_register_addr];
    end
  end

  always_comb begin
    arr_we    = 1'b0;
    arr_waddr = bus.i_register_addr;
    arr_wdata = bus.i_register_write_data;
    if (accept_write && addr_ok && (bus.i_register_addr != 5'd0)) begin
      arr_we = !i_rst;
    end
`ifdef REGFILE_CLEAR_SWEEP_EN
    if (state == CLEAR) begin
      arr_we    = !i_rst;
      arr_waddr = sweep_cnt;
      arr_wdata = '0;
    end
`endif
  end

  // Storage has no reset; reset only suppresses the write on its edge.
  always_ff @(posedge i_clk) begin
    if (arr_we) begin
      regs[arr_waddr] <= arr_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state                      <= IDLE;
      bus.o_register_read_data   <= '0;
      bus.o_register_read_valid  <= 1'b0;
      bus.o_register_write_valid <= 1'b0;
      bus.o_register_busy        <= 1'b0;
`ifdef REGFILE_CLEAR_SWEEP_EN
      sweep_cnt                  <= 5'd0;
`endif
    end else begin
      bus.o_register_read_valid  <= 1'b0;
      bus.o_register_write_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_req) begin
`ifdef REGFILE_CLEAR_SWEEP_EN
            state               <= CLEAR;
            sweep_cnt           <= 5'd1;
            bus.o_register_busy <= 1'b1;
`endif
          end else if (accept_write) begin
            state                      <= WRITE_RESP;
            bus.o_register_write_valid <= 1'b1;
            bus.o_register_busy        <= 1'b1;
          end else if (accept_read) begin
            state                     <= READ_RESP;
            bus.o_register_read_data  <= read_val;
            bus.o_register_read_valid <= 1'b1;
            bus.o_register_busy       <= 1'b1;
          end
        end
        READ_RESP, WRITE_RESP: begin
          state               <= IDLE;
          bus.o_register_busy <= 1'b0;
        end
`ifdef REGFILE_CLEAR_SWEEP_EN
        CLEAR: begin
          if (sweep_cnt == LAST_REG) begin
            state               <= IDLE;
            sweep_cnt           <= 5'd0;
            bus.o_register_busy <= 1'b0;
          end else begin
            sweep_cnt <= sweep_cnt + 5'd1;
          end
        end
`endif
        default: begin
          state               <= IDLE;
          bus.o_register_busy <= 1'b0;
        end
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_rv32i_register_file.sv
// Self-checking bench for rv32i_register_file: directed cases plus random traffic against an array model.
// Clear-sweep cases are compiled only when REGFILE_CLEAR_SWEEP_EN is defined.
module tb_rv32i_register_file;
  localparam int W = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] dbg_state;

  rv32i_register_file_if #(.WORD_SIZE(W)) bus ();

  rv32i_register_file #(.WORD_SIZE(W), .NUM_REGS(32)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock/reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected test completion");
    $fatal(1, "watchdog expired");
  end

  // scoreboard state: bit W marks a read response, low bits hold the expected read data
  logic [W:0]   exp_q[$];
  logic [W-1:0] model [32];
  bit           known [32];
  int           n_checks = 0;
  int           n_fail   = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // monitor
  always @(negedge clk) begin
    logic [W:0] e;
    if (!rst && (bus.o_register_read_valid || bus.o_register_write_valid)) begin
      check("single_valid", 32'(bus.o_register_read_valid & bus.o_register_write_valid), 32'd0);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid: got read_valid=%0b write_valid=%0b, expected no response",
                 bus.o_register_read_valid, bus.o_register_write_valid);
      end else begin
        e = exp_q.pop_front();
        check("resp_kind", 32'(bus.o_register_read_valid), 32'(e[W]));
        if (e[W]) check("read_data", bus.o_register_read_data, e[W-1:0]);
      end
    end
  end

  // drivers: every task starts and ends on a negedge in an IDLE cycle
  task automatic wait_valid(input bit want_read, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(want_read ? bus.o_register_read_valid : bus.o_register_write_valid) && lat < 20);
  endtask

  task automatic do_write(input logic [4:0] a, input logic [W-1:0] d);
    int lat;
    exp_q.push_back({1'b0, d});
    if (a != 5'd0) begin
      model[a] = d;
      known[a] = 1'b1;
    end
    bus.i_register_addr       = a;
    bus.i_register_write_data = d;
    bus.i_register_write_en   = 1'b1;
    wait_valid(1'b0, lat);
    check("write_latency", 32'(lat), 32'd1);
    bus.i_register_write_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_read(input logic [4:0] a);
    int lat;
    exp_q.push_back({1'b1, (a == 5'd0) ? {W{1'b0}} : model[a]});
    bus.i_register_addr    = a;
    bus.i_register_read_en = 1'b1;
    wait_valid(1'b1, lat);
    check("read_latency", 32'(lat), 32'd1);
    bus.i_register_read_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_read_data"},   bus.o_register_read_data, 32'd0);
    check({tag, "_read_valid"},  32'(bus.o_register_read_valid), 32'd0);
    check({tag, "_write_valid"}, 32'(bus.o_register_write_valid), 32'd0);
    check({tag, "_busy"},        32'(bus.o_register_busy), 32'd0);
    check({tag, "_state"},       32'(dbg_state), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      model[i] = '0;
      known[i] = (i == 0);
    end
    rst                       = 1'b1;
    bus.i_register_rst        = 1'b0;
    bus.i_register_read_en    = 1'b0;
    bus.i_register_write_en   = 1'b0;
    bus.i_register_addr       = '0;
    bus.i_register_write_data = '0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // basic write then read, and the x0 cases
    do_write(5'd5, 32'hDEADBEEF);
    do_read(5'd5);
    do_write(5'd0, 32'h12345678);
    do_read(5'd0);

    // simultaneous enables: write first, held read picked up one IDLE cycle later
    exp_q.push_back({1'b0, 32'hA5A5A5A5});
    model[7] = 32'hA5A5A5A5;
    known[7] = 1'b1;
    exp_q.push_back({1'b1, 32'hA5A5A5A5});
    bus.i_register_addr       = 5'd7;
    bus.i_register_write_data = 32'hA5A5A5A5;
    bus.i_register_write_en   = 1'b1;
    bus.i_register_read_en    = 1'b1;
    @(negedge clk);
    check("both_n1_write_valid", 32'(bus.o_register_write_valid), 32'd1);
    check("both_n1_read_valid",  32'(bus.o_register_read_valid), 32'd0);
    bus.i_register_write_en = 1'b0;
    @(negedge clk);
    check("both_n2_read_valid",  32'(bus.o_register_read_valid), 32'd0);
    @(negedge clk);
    check("both_n3_read_valid",  32'(bus.o_register_read_valid), 32'd1);
    bus.i_register_read_en = 1'b0;
    @(negedge clk);

    // read enable held four cycles yields two reads
    do_write(5'd3, $urandom);
    exp_q.push_back({1'b1, model[3]});
    exp_q.push_back({1'b1, model[3]});
    check("hold_c0_read_valid", 32'(bus.o_register_read_valid), 32'd0);
    bus.i_register_addr    = 5'd3;
    bus.i_register_read_en = 1'b1;
    @(negedge clk);
    check("hold_c1_read_valid", 32'(bus.o_register_read_valid), 32'd1);
    @(negedge clk);
    check("hold_c2_read_valid", 32'(bus.o_register_read_valid), 32'd0);
    @(negedge clk);
    check("hold_c3_read_valid", 32'(bus.o_register_read_valid), 32'd1);
    bus.i_register_read_en = 1'b0;
    @(negedge clk);
    check("hold_c4_read_valid", 32'(bus.o_register_read_valid), 32'd0);

`ifdef REGFILE_CLEAR_SWEEP_EN
    begin
      int busy_cnt;
      // full sweep with enables asserted mid-sweep
      for (int i = 1; i < 32; i++) do_write(5'(i), 32'(i));
      bus.i_register_rst = 1'b1;
      @(negedge clk);
      bus.i_register_rst = 1'b0;
      busy_cnt = 0;
      while (bus.o_register_busy && busy_cnt < 100) begin
        busy_cnt++;
        if (busy_cnt == 5) begin
          bus.i_register_addr       = 5'd4;
          bus.i_register_write_data = 32'hFFFFFFFF;
          bus.i_register_write_en   = 1'b1;
          bus.i_register_read_en    = 1'b1;
        end
        if (busy_cnt == 20) begin
          bus.i_register_write_en = 1'b0;
          bus.i_register_read_en  = 1'b0;
        end
        @(negedge clk);
      end
      check("clear_busy_cycles", 32'(busy_cnt), 32'd31);
      check("clear_end_state", 32'(dbg_state), 32'd0);
      for (int i = 1; i < 32; i++) model[i] = '0;
      for (int i = 1; i < 32; i++) do_read(5'(i));

      // reset during the tenth sweep cycle aborts the clear
      for (int i = 1; i < 32; i++) do_write(5'(i), 32'(i));
      bus.i_register_rst = 1'b1;
      @(negedge clk);
      bus.i_register_rst = 1'b0;
      repeat (9) @(negedge clk);
      check("abort_busy_before", 32'(bus.o_register_busy), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      check_outputs_zero("abort");
      rst = 1'b0;
      for (int i = 1; i < 10; i++) model[i] = '0;
      known[10] = 1'b0;
      @(negedge clk);
      do_read(5'd20);
      do_read(5'd5);
    end
`else
    // without the sweep, i_register_rst must not block a read
    bus.i_register_rst = 1'b1;
    do_read(5'd5);
    bus.i_register_rst = 1'b0;
`endif

    // random traffic against the model
    for (int k = 0; k < 80; k++) begin
      logic [4:0] a;
      a = 5'($urandom_range(0, 31));
      if (($urandom_range(0, 1) == 1) && known[a]) do_read(a);
      else do_write(a, $urandom);
    end

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
